// File: rtl/hsi_ratio_scheduler_if.sv
// hsi_ratio_scheduler_if: frame-request, omega snapshot and lock-result bundle for the
// adjacent-band phi-ratio scheduler.
`default_nettype none

interface hsi_ratio_scheduler_if #(
  parameter int WIDTH = 18
);
  logic                    clk_en;
  logic signed [WIDTH-1:0] omega_theta;
  logic signed [WIDTH-1:0] omega_alpha;
  logic signed [WIDTH-1:0] omega_beta1;
  logic signed [WIDTH-1:0] omega_beta2;
  logic signed [WIDTH-1:0] omega_gamma;
  logic                    busy;
  logic                    valid;
  logic [3:0]              pair_lock;
  logic [2:0]              lock_count;
  logic                    all_locked;
  logic [WIDTH+1:0]        dev_sum;
  logic [7:0]              overrun_cnt;

  modport master (
    output clk_en, omega_theta, omega_alpha, omega_beta1, omega_beta2, omega_gamma,
    input  busy, valid, pair_lock, lock_count, all_locked, dev_sum, overrun_cnt
  );

  modport slave (
    input  clk_en, omega_theta, omega_alpha, omega_beta1, omega_beta2, omega_gamma,
    output busy, valid, pair_lock, lock_count, all_locked, dev_sum, overrun_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hsi_ratio_scheduler.sv
// hsi_ratio_scheduler: evaluates the four adjacent-band phi-ratio checks through one shared
// signed multiplier. Define HSI_SCHED_OVERRUN_EN to enable the dropped-request counter.
`default_nettype none

module hsi_ratio_scheduler #(
  parameter int WIDTH = 18,
  parameter int FRAC  = 14,
  parameter int PHI   = 26510,
  parameter int TOL   = 819
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hsi_ratio_scheduler_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  // Deviation path carries a few guard bits so |hi - pred| never wraps before clipping.
  localparam int DW = WIDTH + 3;
  localparam logic [WIDTH-1:0]     DEV_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [DW-1:0]        DEV_MAX_X = {{(DW-WIDTH){1'b0}}, DEV_MAX};
  localparam logic signed [PW-1:0] PHI_X     = PW'(PHI);
  localparam logic signed [PW-1:0] TOL_X     = PW'(TOL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRED = 2'd1,
    S_TOLR = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              k_q, k_d;
  logic signed [DW-1:0]    pred_q, pred_d;
  logic [WIDTH+1:0]        sum_q, sum_d;
  logic [3:0]              lock_q, lock_d;
  logic [3:0]              pair_lock_q, pair_lock_d;
  logic [2:0]              lock_count_q, lock_count_d;
  logic                    all_locked_q, all_locked_d;
  logic [WIDTH+1:0]        dev_sum_q, dev_sum_d;
  logic                    valid_q, valid_d;
  logic signed [WIDTH-1:0] om_q [5];

  logic                    accept;
  logic signed [WIDTH-1:0] omega_lo;
  logic signed [WIDTH-1:0] omega_hi;
  logic signed [PW-1:0]    mul_a;
  logic signed [PW-1:0]    mul_b;
  logic signed [PW-1:0]    product;
  logic signed [DW-1:0]    mul_shift;
  logic signed [DW-1:0]    diff;
  logic [DW-1:0]           abs_diff;
  logic [WIDTH-1:0]        dev_clip;
  logic [WIDTH-1:0]        dev_eff;
  logic                    lo_pos;
  logic                    lock_now;

  assign accept = (state_q == S_IDLE) && bus.clk_en;

  always_comb begin
    omega_lo = om_q[0];
    omega_hi = om_q[1];
    case (k_q)
      2'd0: begin omega_lo = om_q[0]; omega_hi = om_q[1]; end
      2'd1: begin omega_lo = om_q[1]; omega_hi = om_q[2]; end
      2'd2: begin omega_lo = om_q[2]; omega_hi = om_q[3]; end
      default: begin omega_lo = om_q[3]; omega_hi = om_q[4]; end
    endcase
  end

  // The single multiplier: omega_lo times PHI in PRED, times TOL in TOLR.
  assign mul_a     = {{WIDTH{omega_lo[WIDTH-1]}}, omega_lo};
  assign mul_b     = (state_q == S_TOLR) ? TOL_X : PHI_X;
  assign product   = mul_a * mul_b;
  assign mul_shift = DW'(product >>> FRAC);

  assign diff     = {{(DW-WIDTH){omega_hi[WIDTH-1]}}, omega_hi} - pred_q;
  assign abs_diff = diff[DW-1] ? -diff : diff;
  assign dev_clip = (abs_diff > DEV_MAX_X) ? DEV_MAX : abs_diff[WIDTH-1:0];
  assign lo_pos   = ~omega_lo[WIDTH-1] & (|omega_lo);
  // tol is non-negative whenever lo_pos holds, so an unsigned compare is safe.
  assign lock_now = lo_pos && ({{(DW-WIDTH){1'b0}}, dev_clip} <= mul_shift);
  assign dev_eff  = lo_pos ? dev_clip : DEV_MAX;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    pred_d       = pred_q;
    sum_d        = sum_q;
    lock_d       = lock_q;
    pair_lock_d  = pair_lock_q;
    lock_count_d = lock_count_q;
    all_locked_d = all_locked_q;
    dev_sum_d    = dev_sum_q;
    valid_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.clk_en) begin
          sum_d   = '0;
          lock_d  = '0;
          k_d     = '0;
          state_d = S_PRED;
        end
      end
      S_PRED: begin
        pred_d  = mul_shift;
        state_d = S_TOLR;
      end
      S_TOLR: begin
        sum_d       = sum_q + {2'b00, dev_eff};
        lock_d[k_q] = lock_now;
        if (k_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_PRED;
        end
      end
      S_DONE: begin
        pair_lock_d  = lock_q;
        lock_count_d = {2'b00, lock_q[0]} + {2'b00, lock_q[1]}
                     + {2'b00, lock_q[2]} + {2'b00, lock_q[3]};
        all_locked_d = &lock_q;
        dev_sum_d    = sum_q;
        valid_d      = 1'b1;
        k_d          = '0;
        state_d      = S_IDLE;
      end
      default: begin
        k_d     = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      pred_q       <= '0;
      sum_q        <= '0;
      lock_q       <= '0;
      pair_lock_q  <= '0;
      lock_count_q <= '0;
      all_locked_q <= 1'b0;
      dev_sum_q    <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pred_q       <= pred_d;
      sum_q        <= sum_d;
      lock_q       <= lock_d;
      pair_lock_q  <= pair_lock_d;
      lock_count_q <= lock_count_d;
      all_locked_q <= all_locked_d;
      dev_sum_q    <= dev_sum_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) om_q[i] <= '0;
    end else if (accept) begin
      om_q[0] <= bus.omega_theta;
      om_q[1] <= bus.omega_alpha;
      om_q[2] <= bus.omega_beta1;
      om_q[3] <= bus.omega_beta2;
      om_q[4] <= bus.omega_gamma;
    end
  end

`ifdef HSI_SCHED_OVERRUN_EN
  logic [7:0] overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= '0;
    end else if (bus.clk_en && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign bus.overrun_cnt = overrun_q;
`else
  assign bus.overrun_cnt = '0;
`endif

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.valid      = valid_q;
  assign bus.pair_lock  = pair_lock_q;
  assign bus.lock_count = lock_count_q;
  assign bus.all_locked = all_locked_q;
  assign bus.dev_sum    = dev_sum_q;

endmodule

`default_nettype wire

// File: tb/tb_hsi_ratio_scheduler.sv
// tb_hsi_ratio_scheduler: directed frames with hand-computed lock/deviation results,
// back-to-back request pacing and mid-frame reset.
`default_nettype none

module tb_hsi_ratio_scheduler;

  localparam int WIDTH = 18;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  hsi_ratio_scheduler_if #(.WIDTH(WIDTH)) bus ();

  hsi_ratio_scheduler #(
    .WIDTH(WIDTH),
    .FRAC (14),
    .PHI  (26510),
    .TOL  (819)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_omega(input int t, input int a, input int b1, input int b2, input int g);
    bus.omega_theta = WIDTH'(t);
    bus.omega_alpha = WIDTH'(a);
    bus.omega_beta1 = WIDTH'(b1);
    bus.omega_beta2 = WIDTH'(b2);
    bus.omega_gamma = WIDTH'(g);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    32'(bus.busy), 0);
    check({tag, "_valid"},   32'(bus.valid), 0);
    check({tag, "_plock"},   32'(bus.pair_lock), 0);
    check({tag, "_lcount"},  32'(bus.lock_count), 0);
    check({tag, "_alllock"}, 32'(bus.all_locked), 0);
    check({tag, "_devsum"},  32'(bus.dev_sum), 0);
    check({tag, "_overrun"}, 32'(bus.overrun_cnt), 0);
  endtask

  // One request; omegas are scrambled after acceptance to prove they were snapshotted.
  task automatic run_frame(input string tag, input int t, input int a, input int b1,
                           input int b2, input int g, input int exp_lock,
                           input int exp_cnt, input int exp_sum);
    int lat;
    bit got;
    @(negedge clk);
    set_omega(t, a, b1, b2, g);
    bus.clk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.clk_en = 1'b0;
    set_omega(7, -3, 9999, 0, 12345);
    check({tag, "_busy"}, 32'(bus.busy), 1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.valid) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 9);
    check({tag, "_plock"},   32'(bus.pair_lock), 32'(exp_lock));
    check({tag, "_lcount"},  32'(bus.lock_count), 32'(exp_cnt));
    check({tag, "_alllock"}, 32'(bus.all_locked), (exp_lock == 15) ? 1 : 0);
    check({tag, "_devsum"},  32'(bus.dev_sum), 32'(exp_sum));
    @(posedge clk);
    #1;
    check({tag, "_vpulse"}, 32'(bus.valid), 0);
    check({tag, "_idle"},   32'(bus.busy), 0);
    check({tag, "_hold"},   32'(bus.pair_lock), 32'(exp_lock));
  endtask

  initial begin
    logic [31:0] vmask;
    int          vcnt;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.clk_en = 1'b0;
    set_omega(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("phi_exact", 100, 161, 261, 422, 683,  'hF, 4, 2);
    run_frame("near_phi",  152, 245, 397, 642, 1040, 'hF, 4, 3);
    run_frame("flat",      100, 100, 100, 100, 100,  'h0, 0, 244);
    run_frame("octave",    100, 200, 400, 800, 1600, 'h0, 0, 575);
    run_frame("theta_zero",  0, 161, 261, 422, 683,  'hE, 3, 131073);
    run_frame("tol_edge",  100, 165, 274, 457, 717,  'hB, 3, 48);

    // clk_en held for 30 edges: accepted at 0, 10, 20; valid after edges 9, 19, 29.
    @(negedge clk);
    set_omega(100, 161, 261, 422, 683);
    bus.clk_en = 1'b1;
    vmask = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      vmask[i] = bus.valid;
    end
    bus.clk_en = 1'b0;
    check("hold_vmask", vmask, 32'h2008_0200);
`ifdef HSI_SCHED_OVERRUN_EN
    check("hold_overrun", 32'(bus.overrun_cnt), 27);
    bus.clk_en = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    bus.clk_en = 1'b0;
    check("overrun_sat", 32'(bus.overrun_cnt), 255);
`else
    check("hold_overrun", 32'(bus.overrun_cnt), 0);
`endif
    repeat (12) @(posedge clk);
    #1;
    check("pre_rst_plock", 32'(bus.pair_lock), 'hF);

    // Mid-frame async reset after edge 4 of a frame.
    @(negedge clk);
    bus.clk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.clk_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid) vcnt++;
    end
    check("midrst_novalid", 32'(vcnt), 0);
    check("midrst_idle", 32'(bus.busy), 0);

    run_frame("post_rst", 152, 245, 397, 642, 1040, 'hF, 4, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
